// File: rtl/s2p.sv
// -----------------------------------------------------------------------------
// s2p : serial-to-parallel deserializer
//
// Collects N single-bit beats from a valid/ready serial link into an N-bit
// word. Completed words go into a small output FIFO (DEPTH entries, any
// depth >= 1), so the serial side keeps moving while the parallel consumer
// stalls. This is the stage directly downstream of p2s, and the pair forms a
// bit-exact loopback.
//
// Handshake semantics (both links):
//   A beat transfers on a rising clk edge where valid & ready are both 1.
//   A producer holding valid=1 must not depend on ready to raise valid.
//   ready is a function of registered state only. No combinational path
//   exists from par_ready to ser_ready, or from ser_* to par_*.
//
// Parameters
//   N          word width in bits (>= 2)
//   LSB_FIRST  1: first serial bit lands in par_data[0]
//              0: first serial bit lands in par_data[N-1]
//   DEPTH      output FIFO entries (>= 1, need not be a power of two)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high. Drops any partial word and
//              the FIFO contents.
//   ser_data   serial bit, ignored unless ser_valid & ser_ready
//   ser_valid  ser_data is valid
//   ser_ready  a bit is accepted this cycle. Only the final bit of a word
//              can stall, and only while the FIFO is full.
//   par_data   word at the FIFO head (0 when empty)
//   par_valid  FIFO non-empty
//   par_ready  consumer takes par_data
//   busy       partial word in progress or FIFO non-empty
// -----------------------------------------------------------------------------
module s2p #(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int DEPTH     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ser_data,
  input  logic         ser_valid,
  output logic         ser_ready,
  output logic [N-1:0] par_data,
  output logic         par_valid,
  input  logic         par_ready,
  output logic         busy
);

  localparam int CNT_W = $clog2(N);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [N-1:0]     shift_q,   shift_d;
  logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
  logic [OCC_W-1:0] occ_q,     occ_d;
  logic [N-1:0]     mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic         final_bit;
  logic         ser_accept;
  logic         push;
  logic         pop;
  logic [N-1:0] word_in;

  assign final_bit  = (bit_cnt_q == LAST_BIT);
  assign ser_accept = ser_valid & ser_ready;
  assign push       = ser_accept & final_bit;
  assign pop        = par_valid & par_ready;

  // The shift register shifts toward the end that the first bit must reach.
  // After N accepts, the first bit sits at index 0 (LSB_FIRST) or at N-1.
  // The shifted value with the current bit included is therefore the complete
  // word on the final beat.
  always_comb begin
    word_in = '0;
    if (LSB_FIRST) begin
      word_in = {ser_data, shift_q[N-1:1]};
    end else begin
      word_in = {shift_q[N-2:0], ser_data};
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;

    if (ser_accept) begin
      if (final_bit) begin
        // The word leaves through the FIFO. Clearing the shift register
        // keeps the next word free of residue.
        bit_cnt_d = '0;
        shift_d   = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        shift_d   = word_in;
      end
    end

    // The pointers wrap explicitly, so DEPTH need not be a power of two.
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    // A simultaneous push and pop leaves the occupancy unchanged.
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
    end
  end

  // Storage needs no reset. An entry is only visible while occ_q says it is
  // live, and occ_q is cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= word_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (registered state only)
  // ---------------------------------------------------------------------------
  // The final bit may only stall while the FIFO is full. Earlier bits never
  // need FIFO space.
  assign ser_ready = !final_bit || (occ_q < FULL_OCC);
  assign par_valid = (occ_q != '0);
  assign par_data  = par_valid ? mem_q[rd_ptr_q] : '0;
  assign busy      = (bit_cnt_q != '0) || par_valid;

endmodule

// File: tb/tb_s2p.sv
// -----------------------------------------------------------------------------
// tb_s2p : self-checking bench for s2p
//
// dut0 : N=8, LSB_FIRST=1, DEPTH=2. Directed scenarios plus random traffic,
//        checked every cycle against a queue-based reference model.
// dut1 : N=8, LSB_FIRST=0, DEPTH=3. Loopback from a behavioural MSB-first p2s
//        with random stalls on both sides.
// -----------------------------------------------------------------------------
module tb_s2p;

  localparam int N     = 8;
  localparam int DEPTH = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut0 signals
  logic         rst = 1'b1;
  logic         ser_data = 1'b0, ser_valid = 1'b0, par_ready = 1'b0;
  logic         ser_ready, par_valid, busy;
  logic [N-1:0] par_data;

  // dut1 signals
  logic         rst1 = 1'b1;
  logic         ser_data1 = 1'b0, ser_valid1 = 1'b0, par_ready1 = 1'b0;
  logic         ser_ready1, par_valid1, busy1;
  logic [N-1:0] par_data1;

  s2p #(.N(N), .LSB_FIRST(1'b1), .DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst(rst),
    .ser_data(ser_data), .ser_valid(ser_valid), .ser_ready(ser_ready),
    .par_data(par_data), .par_valid(par_valid), .par_ready(par_ready),
    .busy(busy)
  );

  s2p #(.N(N), .LSB_FIRST(1'b0), .DEPTH(3)) dut1 (
    .clk(clk), .rst(rst1),
    .ser_data(ser_data1), .ser_valid(ser_valid1), .ser_ready(ser_ready1),
    .par_data(par_data1), .par_valid(par_valid1), .par_ready(par_ready1),
    .busy(busy1)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model for dut0: bits of the word in progress, words waiting.
  logic         pbits[$];
  logic [N-1:0] exp_q[$];

  // Reference model for dut1: words in the order they were sent.
  logic [N-1:0] exp1_q[$];

  // ---------------------------------------------------------------------------
  // dut0 driver: one clock cycle.
  // Drives inputs at the negedge and checks outputs against the model. At the
  // posedge, advances the model.
  // ---------------------------------------------------------------------------
  task automatic step(input logic v, input logic d, input logic pr, input logic r,
                      output logic acc);
    logic         exp_rdy;
    logic         exp_pop;
    logic [N-1:0] w;
    @(negedge clk);
    rst = r; ser_valid = v; ser_data = d; par_ready = pr;
    #1;
    exp_rdy = (pbits.size() != N - 1) || (exp_q.size() < DEPTH);
    check_eq("ser_ready", ser_ready, exp_rdy);
    check_eq("par_valid", par_valid, exp_q.size() != 0);
    check_eq("par_data",  par_data,  (exp_q.size() != 0) ? exp_q[0] : '0);
    check_eq("busy",      busy,      (pbits.size() != 0) || (exp_q.size() != 0));
    acc     = v && exp_rdy && !r;
    exp_pop = (exp_q.size() != 0) && pr && !r;
    @(posedge clk);
    if (r) begin
      pbits.delete();
      exp_q.delete();
    end else begin
      if (exp_pop) void'(exp_q.pop_front());
      if (acc) begin
        pbits.push_back(d);
        if (pbits.size() == N) begin
          // The first bit received is the word's LSB.
          w = '0;
          for (int i = 0; i < N; i++) w = w | (N'(pbits[i]) << i);
          exp_q.push_back(w);
          pbits.delete();
        end
      end
    end
  endtask

  task automatic send_word(input logic [N-1:0] w, input logic pr, input logic gappy);
    logic a;
    int   tries;
    for (int i = 0; i < N; i++) begin
      a = 1'b0;
      tries = 0;
      while (!a) begin
        if (gappy) step(1'b0, 1'($urandom_range(0, 1)), pr, 1'b0, a);
        step(1'b1, w[i], pr, 1'b0, a);
        tries++;
        if (tries > 50) begin
          check_eq("send_timeout", ser_ready, 1'b1);
          return;
        end
      end
    end
  endtask

  task automatic idle(input int cycles, input logic pr);
    logic a;
    for (int i = 0; i < cycles; i++) step(1'b0, 1'($urandom_range(0, 1)), pr, 1'b0, a);
  endtask

  // ---------------------------------------------------------------------------
  // dut1 loopback: behavioural MSB-first p2s producer and a random consumer
  // ---------------------------------------------------------------------------
  bit lb_done = 1'b0;

  initial begin : lb_producer
    logic [N-1:0] fixed_words [5];
    logic [N-1:0] w;
    logic         acc;
    int           tries;
    fixed_words = '{8'd7, 8'd62, 8'd52, 8'd255, 8'd0};
    repeat (2) @(negedge clk);
    rst1 = 1'b0;
    for (int k = 0; k < 30; k++) begin
      w = (k < 5) ? fixed_words[k] : N'($urandom_range(0, 255));
      exp1_q.push_back(w);
      for (int i = 0; i < N; i++) begin
        acc = 1'b0;
        tries = 0;
        while (!acc && tries <= 200) begin
          @(negedge clk);
          ser_valid1 = ($urandom_range(0, 3) != 0);
          // Junk on ser_data during a gap must be ignored.
          ser_data1  = ser_valid1 ? w[N-1-i] : 1'($urandom_range(0, 1));
          #1;
          acc = ser_valid1 && ser_ready1;
          tries++;
        end
        if (!acc) check_eq("lb_send_timeout", ser_ready1, 1'b1);
      end
    end
    @(negedge clk);
    ser_valid1 = 1'b0;
    lb_done = 1'b1;
  end

  initial begin : lb_consumer
    forever begin
      @(negedge clk);
      par_ready1 = ($urandom_range(0, 2) != 0);
      #1;
      if (par_valid1 && par_ready1) begin
        if (exp1_q.size() == 0) check_eq("lb_unexpected_word", par_valid1, 1'b0);
        else                    check_eq("lb_word", par_data1, exp1_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Main sequence for dut0
  // ---------------------------------------------------------------------------
  initial begin : main
    logic         a;
    logic [N-1:0] w7;
    int           wait_cyc;
    w7 = 8'd7;

    // 1: reset, then a single word with a ready consumer
    step(1'b0, 1'b0, 1'b1, 1'b1, a);
    @(negedge clk); #1;
    check_eq("rst_par_valid", par_valid, 1'b0);
    check_eq("rst_par_data",  par_data,  '0);
    check_eq("rst_busy",      busy,      1'b0);
    check_eq("rst_ser_ready", ser_ready, 1'b1);
    send_word(8'd62, 1'b1, 1'b0);
    idle(3, 1'b1);

    // 2: backpressure. Two words fill the FIFO, so the third word's
    //    final bit stalls.
    send_word(8'd62, 1'b0, 1'b0);
    send_word(8'd52, 1'b0, 1'b0);
    for (int i = 0; i < N - 1; i++) step(1'b1, w7[i], 1'b0, 1'b0, a);
    step(1'b1, w7[N-1], 1'b0, 1'b0, a);
    #1;
    check_eq("bp_ser_ready_low", ser_ready, 1'b0);
    step(1'b1, w7[N-1], 1'b1, 1'b0, a);   // pop; the final bit is still stalled
    step(1'b1, w7[N-1], 1'b1, 1'b0, a);   // final bit accepted here
    idle(5, 1'b1);

    // 3: gappy input
    send_word(8'd62, 1'b1, 1'b1);
    idle(3, 1'b1);

    // 4: reset mid-word, then a clean word
    for (int i = 0; i < 5; i++) step(1'b1, 1'((8'd52 >> i) & 8'd1), 1'b1, 1'b0, a);
    step(1'b0, 1'b0, 1'b1, 1'b1, a);
    @(negedge clk); #1;
    check_eq("midrst_busy", busy, 1'b0);
    send_word(8'd7, 1'b1, 1'b0);
    idle(3, 1'b1);

    // 5: FIFO full with the final bit pending, then pop and push on
    //    consecutive edges
    send_word(8'd170, 1'b0, 1'b0);
    send_word(8'd85, 1'b0, 1'b0);
    for (int i = 0; i < N - 1; i++) step(1'b1, 1'((8'd200 >> i) & 8'd1), 1'b0, 1'b0, a);
    step(1'b1, 1'b1, 1'b1, 1'b0, a);
    step(1'b1, 1'b1, 1'b0, 1'b0, a);
    idle(6, 1'b1);

    // Random traffic with occasional resets and varying consumer pressure
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           (i < 300) ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 149) == 0), a);
    end
    idle(6, 1'b1);

    // Wait for the loopback to finish and drain
    wait_cyc = 0;
    while ((!lb_done || exp1_q.size() != 0) && wait_cyc < 5000) begin
      @(posedge clk);
      wait_cyc++;
    end
    check_eq("lb_words_outstanding", exp1_q.size(), 0);
    repeat (2) @(negedge clk);
    #1;
    check_eq("lb_busy_idle", busy1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
